// File: rtl/parking_lot_ctrl.sv
// parking_lot_ctrl
//   Direction-detect controller for a two-beam lot gate. Decodes the outer
//   sensor A and inner sensor B into complete entry/exit events and pulses the
//   occupancy counter, gating on full/empty read back from that counter.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high
//   sens_a   in   outer beam, raw/asynchronous, 1 = blocked
//   sens_b   in   inner beam, raw/asynchronous, 1 = blocked
//   count    in   [4:0] current occupancy
//   incr     out  one-cycle pulse, entry accepted
//   decr     out  one-cycle pulse, exit accepted
//   full     out  combinational, count >= CAPACITY
//   empty    out  combinational, count == 0
//   blocked  out  one-cycle pulse, entry completed while full
//   fault    out  one-cycle pulse, illegal sequence / underflow exit / timeout
//
// Optional feature: define PARKING_LOT_CTRL_TIMEOUT_EN to abandon any
// in-progress event that stalls for TIMEOUT_CYCLES cycles.
//
// state      | meaning
// IDLE       | no car in the gate, both beams clear
// EN_A       | entering, outer beam only
// EN_AB      | entering, both beams
// EN_B       | entering, inner beam only
// EX_B       | leaving, inner beam only
// EX_AB      | leaving, both beams
// EX_A       | leaving, outer beam only
// WAIT_CLEAR | ignore everything until both beams clear
module parking_lot_ctrl #(
  parameter int CAPACITY       = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sens_a,
  input  logic       sens_b,
  input  logic [4:0] count,
  output logic       incr,
  output logic       decr,
  output logic       full,
  output logic       empty,
  output logic       blocked,
  output logic       fault
);

  if (CAPACITY < 1 || CAPACITY > 16) begin : g_bad_capacity
    $error("parking_lot_ctrl: CAPACITY must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("parking_lot_ctrl: TIMEOUT_CYCLES must be >= 1");
  end

  localparam logic [4:0] CAP5 = 5'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, WAIT_CLEAR
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] a_sync_q, a_sync_d;
  logic [1:0] b_sync_q, b_sync_d;
  logic [1:0] prime_q, prime_d;
  logic       incr_q, incr_d;
  logic       decr_q, decr_d;
  logic       blocked_q, blocked_d;
  logic       fault_q, fault_d;
  logic [1:0] ab;

`ifdef PARKING_LOT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          in_prog;
`endif

  assign full  = (count >= CAP5);
  assign empty = (count == 5'd0);

  assign incr    = incr_q;
  assign decr    = decr_q;
  assign blocked = blocked_q;
  assign fault   = fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_CLEAR;
      a_sync_q  <= 2'b00;
      b_sync_q  <= 2'b00;
      prime_q   <= 2'b00;
      incr_q    <= 1'b0;
      decr_q    <= 1'b0;
      blocked_q <= 1'b0;
      fault_q   <= 1'b0;
`ifdef PARKING_LOT_CTRL_TIMEOUT_EN
      timer_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      a_sync_q  <= a_sync_d;
      b_sync_q  <= b_sync_d;
      prime_q   <= prime_d;
      incr_q    <= incr_d;
      decr_q    <= decr_d;
      blocked_q <= blocked_d;
      fault_q   <= fault_d;
`ifdef PARKING_LOT_CTRL_TIMEOUT_EN
      timer_q   <= timer_d;
`endif
    end
  end

  always_comb begin
    a_sync_d  = {a_sync_q[0], sens_a};
    b_sync_d  = {b_sync_q[0], sens_b};
    // The sync flops hold 00 straight out of reset, which is not a real
    // observation; prime_q marks when the second stage carries a real sample
    // so a car straddling the beams at release cannot look like a clear gate.
    prime_d   = {prime_q[0], 1'b1};
    ab        = {a_sync_q[1], b_sync_q[1]};
    state_d   = state_q;
    incr_d    = 1'b0;
    decr_d    = 1'b0;
    blocked_d = 1'b0;
    fault_d   = 1'b0;

    if (prime_q[1]) begin
      unique case (state_q)
        IDLE: begin
          if (ab == 2'b10) state_d = EN_A;
          else if (ab == 2'b01) state_d = EX_B;
          else if (ab == 2'b11) begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
        end
        EN_A: begin
          if (ab == 2'b11) state_d = EN_AB;
          else if (ab == 2'b00) state_d = IDLE;
          else if (ab == 2'b01) begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
        end
        EN_AB: begin
          if (ab == 2'b01) state_d = EN_B;
          else if (ab == 2'b10) state_d = EN_A;
          else if (ab == 2'b00) begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
        end
        EN_B: begin
          if (ab == 2'b00) begin
            state_d = IDLE;
            if (full) blocked_d = 1'b1;
            else      incr_d    = 1'b1;
          end
          else if (ab == 2'b11) state_d = EN_AB;
          else if (ab == 2'b10) begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
        end
        EX_B: begin
          if (ab == 2'b11) state_d = EX_AB;
          else if (ab == 2'b00) state_d = IDLE;
          else if (ab == 2'b10) begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
        end
        EX_AB: begin
          if (ab == 2'b10) state_d = EX_A;
          else if (ab == 2'b01) state_d = EX_B;
          else if (ab == 2'b00) begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
        end
        EX_A: begin
          if (ab == 2'b00) begin
            state_d = IDLE;
            if (empty) fault_d = 1'b1;
            else       decr_d  = 1'b1;
          end
          else if (ab == 2'b11) state_d = EX_AB;
          else if (ab == 2'b01) begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
        end
        WAIT_CLEAR: begin
          if (ab == 2'b00) state_d = IDLE;
        end
        default: state_d = WAIT_CLEAR;
      endcase
    end

`ifdef PARKING_LOT_CTRL_TIMEOUT_EN
    in_prog = (state_q != IDLE) && (state_q != WAIT_CLEAR);
    timer_d = '0;
    if (in_prog && (state_d == state_q)) begin
      if (timer_q == TW'(TIMEOUT_CYCLES)) begin
        state_d = WAIT_CLEAR;
        fault_d = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
`endif
  end

endmodule

// File: tb/tb_parking_lot_ctrl.sv
module tb_parking_lot_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sens_a = 1'b0;
  logic       sens_b = 1'b0;
  logic [4:0] count = 5'd0;
  logic       incr, decr, full, empty, blocked, fault;

  localparam int CAP = 16;
  localparam int TMO = 20;

  parking_lot_ctrl #(.CAPACITY(CAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b), .count(count),
    .incr(incr), .decr(decr), .full(full), .empty(empty),
    .blocked(blocked), .fault(fault)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: the gate is a ring 00 -> 10 -> 11 -> 01 -> 00. An entry walks it
  // forward, an exit walks it backward; a two-step jump is illegal. Samples
  // reach the decision two edges after capture; -1 means "no sample yet".
  int m_s1 = -1, m_s2 = -1;
  bit m_wait = 1'b1, m_active = 1'b0;
  int m_dir = 0, m_pos = 0, m_rcur = 0, m_stall = 0;
  bit e_incr = 0, e_decr = 0, e_blk = 0, e_flt = 0;

  function automatic int ring(input int v);
    case (v)
      0: return 0;
      2: return 1;
      3: return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    int r, delta;
    if (reset) begin
      m_s1 = -1; m_s2 = -1; m_wait = 1; m_active = 0; m_stall = 0;
      e_incr = 0; e_decr = 0; e_blk = 0; e_flt = 0;
    end else begin
      e_incr = 0; e_decr = 0; e_blk = 0; e_flt = 0;
      if (m_s2 >= 0) begin
        r = ring(m_s2);
        if (m_wait) begin
          if (r == 0) m_wait = 0;
        end else if (!m_active) begin
          m_stall = 0;
          if (r == 1) begin m_active = 1; m_dir = 1; m_pos = 1; m_rcur = 1; end
          else if (r == 3) begin m_active = 1; m_dir = -1; m_pos = 1; m_rcur = 3; end
          else if (r == 2) begin e_flt = 1; m_wait = 1; end
        end else begin
          delta = ((m_dir > 0) ? (r - m_rcur) : (m_rcur - r)) & 3;
          if (delta == 0) begin
`ifdef PARKING_LOT_CTRL_TIMEOUT_EN
            if (m_stall == TMO) begin
              e_flt = 1; m_wait = 1; m_active = 0; m_stall = 0;
            end else m_stall++;
`endif
          end else if (delta == 2) begin
            e_flt = 1; m_wait = 1; m_active = 0; m_stall = 0;
          end else begin
            m_pos += (delta == 1) ? 1 : -1;
            m_rcur = r; m_stall = 0;
            if (m_pos == 4) begin
              m_active = 0;
              if (m_dir > 0) begin
                if (count >= CAP) e_blk = 1; else e_incr = 1;
              end else begin
                if (count == 0) e_flt = 1; else e_decr = 1;
              end
            end else if (m_pos == 0) m_active = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = {sens_a, sens_b};
    end
  end

  int n_incr = 0, n_decr = 0, n_blk = 0, n_flt = 0, last_incr = 0;

  always @(negedge clk) begin
    tests++;
    if ({incr, decr, blocked, fault} !== {e_incr, e_decr, e_blk, e_flt}) begin
      fails++;
      $display("FAIL pulses cyc=%0d got idbf=%b%b%b%b want %b%b%b%b", cyc,
               incr, decr, blocked, fault, e_incr, e_decr, e_blk, e_flt);
    end
    tests++;
    if ({full, empty} !== {(count >= CAP), (count == 0)}) begin
      fails++;
      $display("FAIL full_empty cyc=%0d got %b%b want %b%b", cyc, full, empty,
               (count >= CAP), (count == 0));
    end
    if (incr === 1'b1) begin n_incr++; last_incr = cyc; end
    if (decr === 1'b1) n_decr++;
    if (blocked === 1'b1) n_blk++;
    if (fault === 1'b1) n_flt++;
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  int t_apply;
  task automatic drive(input logic [1:0] v, input int hold);
    @(posedge clk); #2;
    {sens_a, sens_b} = v;
    t_apply = cyc;
    repeat (hold - 1) @(posedge clk);
  endtask

  int b_i, b_d, b_b, b_f;
  task automatic snap();
    b_i = n_incr; b_d = n_decr; b_b = n_blk; b_f = n_flt;
  endtask

  task automatic expect_counts(input string name, input int i, input int d,
                               input int b, input int f);
    repeat (6) @(posedge clk);
    @(negedge clk); #1;
    check({name, "_incr"}, n_incr - b_i, i);
    check({name, "_decr"}, n_decr - b_d, d);
    check({name, "_blocked"}, n_blk - b_b, b);
    check({name, "_fault"}, n_flt - b_f, f);
  endtask

  task automatic entry();
    drive(2'b10, 5); drive(2'b11, 5); drive(2'b01, 5); drive(2'b00, 5);
  endtask

  task automatic exit_seq();
    drive(2'b01, 5); drive(2'b11, 5); drive(2'b10, 5); drive(2'b00, 5);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pulses", {incr, decr, blocked, fault}, 0);
    @(posedge clk); #2 reset = 1'b0;
    repeat (6) @(posedge clk);

    // entry, count 3
    #2 count = 5'd3;
    snap(); entry();
    expect_counts("entry", 1, 0, 0, 0);
    check("incr_latency", last_incr - t_apply, 3);

    // exit, count 5, then underflow with count 0
    #2 count = 5'd5;
    snap(); exit_seq();
    expect_counts("exit", 0, 1, 0, 0);
    #2 count = 5'd0;
    snap(); exit_seq();
    expect_counts("exit_empty", 0, 0, 0, 1);

    // entry while full
    #2 count = 5'd16;
    snap(); entry();
    expect_counts("entry_full", 0, 0, 1, 0);
    check("full_flag", full, 1);

    // back out mid-entry
    #2 count = 5'd3;
    snap(); drive(2'b10, 5); drive(2'b11, 5); drive(2'b10, 5); drive(2'b00, 5);
    expect_counts("backout", 0, 0, 0, 0);

    // illegal 00 -> 11, walk a full entry pattern without clearing: ignored
    snap(); drive(2'b11, 5);
    drive(2'b10, 5); drive(2'b11, 5); drive(2'b01, 5); drive(2'b00, 5);
    expect_counts("illegal", 0, 0, 0, 1);
    snap(); entry();
    expect_counts("after_illegal", 1, 0, 0, 0);

    // reset while both beams blocked mid-entry
    snap(); drive(2'b10, 5); drive(2'b11, 5);
    @(posedge clk); #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    drive(2'b11, 5); drive(2'b01, 5); drive(2'b00, 5);
    expect_counts("reset_mid", 0, 0, 0, 0);
    snap(); entry();
    expect_counts("after_reset", 1, 0, 0, 0);

    // stall in EN_A for 30 cycles
    snap(); drive(2'b10, 30); drive(2'b00, 5);
`ifdef PARKING_LOT_CTRL_TIMEOUT_EN
    expect_counts("stall", 0, 0, 0, 1);
`else
    expect_counts("stall", 0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/parking_lot_ctrl.md
Name: parking_lot_ctrl

Overview:
- Two-sensor direction-detect controller that sequences the lot occupancy counter.
- Decodes outer sensor A and inner sensor B into complete entry and exit events.
- Issues one-cycle incr/decr pulses to the 5-bit counter and reads its count back for full/empty gating.
- Sits between the raw gate photo-sensors and the counter.

Parameters:
CAPACITY, 16, lot size; full when count >= CAPACITY; legal range 1..16.
TIMEOUT_CYCLES, 1000, stall limit in any in-progress state; used only with the optional feature.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
sens_a  in  1  outer sensor, asynchronous raw input, 1 = beam blocked
sens_b  in  1  inner sensor, asynchronous raw input, 1 = beam blocked
count  in  5  current occupancy from the counter
incr  out  1  one-cycle pulse: entry completed and accepted
decr  out  1  one-cycle pulse: exit completed and accepted
full  out  1  combinational, count >= CAPACITY
empty  out  1  combinational, count == 0
blocked  out  1  one-cycle pulse: entry completed while full, no incr
fault  out  1  one-cycle pulse: illegal sensor sequence, underflow exit or timeout

Behaviour:
- Reset values: all registered outputs 0, sync flops 0, FSM in WAIT_CLEAR, timer 0.
- Synchroniser: sens_a and sens_b each pass through 2 flops. The FSM acts on the synchronised pair {a,b}.
- Latency: a raw change sampled at edge N is acted on by the FSM at edge N+2. Any pulse is high for exactly the cycle after edge N+2.
- States: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, WAIT_CLEAR. Transitions below are listed by {a,b} value; an unlisted value means stay.
- IDLE: 10 to EN_A; 01 to EX_B; 11 to WAIT_CLEAR with fault.
- EN_A: 11 to EN_AB; 00 to IDLE (aborted, no pulse); 01 to WAIT_CLEAR with fault.
- EN_AB: 01 to EN_B; 10 to EN_A (backing out); 00 to WAIT_CLEAR with fault.
- EN_B: 00 to IDLE with incr, or with blocked instead if full; 11 to EN_AB; 10 to WAIT_CLEAR with fault.
- EX_B: 11 to EX_AB; 00 to IDLE (no pulse); 10 to WAIT_CLEAR with fault.
- EX_AB: 10 to EX_A; 01 to EX_B; 00 to WAIT_CLEAR with fault.
- EX_A: 00 to IDLE with decr, or with fault instead of decr if empty; 11 to EX_AB; 01 to WAIT_CLEAR with fault.
- WAIT_CLEAR: 00 to IDLE; otherwise stay. Reset exits into this state, so a car straddling the sensors at reset release is never counted.
- Exclusivity: incr, decr, blocked and fault are mutually exclusive. At most one of them is high in any cycle.
- Count sampling: full/empty are evaluated from count in the completion cycle. The counter updates the cycle after incr/decr; completions are always at least 4 cycles apart, so there is no hazard.
- Reset mid-sequence: any in-progress event is discarded and no pulse is emitted. The FSM returns to WAIT_CLEAR.

Optional Feature:
- Macro PARKING_LOT_CTRL_TIMEOUT_EN.
- Defined:
  - A stall timer of width clog2(TIMEOUT_CYCLES+1) clears on every state change and counts while in EN_* or EX_*.
  - When it reaches TIMEOUT_CYCLES with no state change, the FSM goes to WAIT_CLEAR with fault and the timer clears.
  - The timer holds 0 in IDLE and WAIT_CLEAR.
- Undefined: no timer logic; in-progress states wait indefinitely.

Test Plan:
- Reset release with sensors at 00, then entry sequence 10,11,01,00 (each held 5 cycles), count=3 -> one incr pulse 3 cycles after the final 00; no other pulses.
- Exit sequence 01,11,10,00 with count=5 -> one decr pulse; then repeat with count=0 -> fault pulse, no decr.
- Entry sequence with count=16, CAPACITY=16 -> blocked pulse, no incr, full=1 throughout.
- Partial entry 10,11,10,00 (backing out) -> no pulse, FSM back in IDLE. Illegal jump 00 to 11 -> fault pulse, then waits for 00 before accepting a new entry.
- Assert reset while in EN_AB with sensors at 11, release with 11 held, then 01,00 -> no incr, no fault; FSM enters IDLE only after 00.
- With PARKING_LOT_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=20, hold 10 for 30 cycles -> fault pulse at the 20th stalled cycle and WAIT_CLEAR. Without the macro -> no fault.
